// File: rtl/key_pkg.sv
// Shared types and helpers for the key debounce front end.
// Holds the per-channel state encoding and the counter width helper.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_e;

    // $clog2 clamped so that tiny counts still get a 1-bit counter
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM and press/release pulses.
// Optional long-press hold counter is built when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int LONG_CYCLES     = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw_i,
    output logic key_level_o,
    output logic key_press_o,
    output logic key_release_o,
    output logic long_press_o
);

    localparam int              CNT_W        = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic            RELEASED_PIN = ACTIVE_LOW;

    logic             sync1_q;
    logic             sync2_q;
    logic             pressed;
    key_state_e       state_q;
    key_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Flops preset to the released pin level so reset never looks like a press
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= RELEASED_PIN;
            sync2_q <= RELEASED_PIN;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_CHK: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_CHK: begin
                if (pressed) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_level_o   = (state_q == HELD) || (state_q == RELEASE_CHK);
    assign key_press_o   = press_q;
    assign key_release_o = release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int               HOLD_W    = cnt_width(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);

    logic              holding;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              long_q;
    logic              long_d;

    assign holding = (state_q == HELD) || (state_q == RELEASE_CHK);

    // Hold time survives a rejected release; it stops at the limit so one hold gives one pulse
    always_comb begin
        hold_d = hold_q;
        long_d = holding && (hold_q == HOLD_PRE);
        if (state_d == IDLE || (state_q == PRESS_CHK && state_d == HELD)) begin
            hold_d = '0;
        end else if (holding && hold_q != HOLD_LAST) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press_o = long_q;
`else
    assign long_press_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-key debounce front end: one independent channel per key pin.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to enable the long_press pulses.
module key_debounce
    import key_pkg::*;
#(
    parameter int KEYS            = 4,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int LONG_CYCLES     = 1000000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [KEYS-1:0] key_raw,
    output logic [KEYS-1:0] key_level,
    output logic [KEYS-1:0] key_press,
    output logic [KEYS-1:0] key_release,
    output logic [KEYS-1:0] long_press
);

    for (genvar k = 0; k < KEYS; k++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_chan (
            .clock        (clock),
            .reset        (reset),
            .key_raw_i    (key_raw[k]),
            .key_level_o  (key_level[k]),
            .key_press_o  (key_press[k]),
            .key_release_o(key_release[k]),
            .long_press_o (long_press[k])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a scoreboard of expected pulse events.
// Long-press expectations follow KEY_DEBOUNCE_LONG_PRESS_EN.
module tb_key_debounce;

    localparam int K = 2;
    localparam int D = 4;
    localparam int L = 10;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } evt_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [K-1:0] key_raw;
    logic [K-1:0] key_level;
    logic [K-1:0] key_press;
    logic [K-1:0] key_release;
    logic [K-1:0] long_press;

    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    evt_t         sb[$];
    logic [K-1:0] expLevel = '0;

    key_debounce #(
        .KEYS           (K),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (1'b1),
        .LONG_CYCLES    (L)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .long_press (long_press)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive new pin levels; changed bits in acceptMask are held long enough to be accepted
    task automatic applyStimulus(input logic [K-1:0] newRaw, input logic [K-1:0] acceptMask);
        int at;
        at = cyc + D + 2;
        for (int ch = 0; ch < K; ch++) begin
            if (newRaw[ch] != key_raw[ch] && acceptMask[ch]) begin
                if (newRaw[ch] == 1'b0) begin
                    sb.push_back('{at, ch, 0});
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
                    sb.push_back('{at + L, ch, 2});
`endif
                end else begin
                    sb.push_back('{at, ch, 1});
                    for (int i = sb.size() - 1; i >= 0; i--) begin
                        if (sb[i].kind == 2 && sb[i].ch == ch && sb[i].cyc > at)
                            sb.delete(i);
                    end
                end
            end
        end
        key_raw = newRaw;
    endtask

    always @(negedge clock) begin
        int expMask;
        int obsMask;
        expMask = 0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                expMask |= 1 << (sb[i].kind * K + sb[i].ch);
                if (sb[i].kind == 0) expLevel[sb[i].ch] = 1'b1;
                else if (sb[i].kind == 1) expLevel[sb[i].ch] = 1'b0;
                sb.delete(i);
            end
        end
        obsMask = (int'(long_press) << (2 * K)) | (int'(key_release) << K) | int'(key_press);
        if (obsMask != 0 || expMask != 0)
            checkOutput($sformatf("pulses c%0d", cyc), obsMask, expMask);
        checkOutput($sformatf("level c%0d", cyc), int'(key_level), int'(expLevel));
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not finish, got running, wanted done");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset   = 1'b1;
        key_raw = 2'b11;
        waitCycles(3);
        checkOutput("rst_level", int'(key_level), 0);
        checkOutput("rst_press", int'(key_press), 0);
        checkOutput("rst_long", int'(long_press), 0);
        reset = 1'b0;
        waitCycles(50);
        checkOutput("idle_level", int'(key_level), 0);

        // Stable press of key 0, a short release glitch, then a real release
        applyStimulus(2'b10, 2'b01);
        waitCycles(30);
        applyStimulus(2'b11, 2'b00);
        waitCycles(2);
        applyStimulus(2'b10, 2'b00);
        waitCycles(20);
        checkOutput("held_level", int'(key_level), 1);
        applyStimulus(2'b11, 2'b01);
        waitCycles(20);

        // Press bounces shorter than the debounce window
        applyStimulus(2'b10, 2'b00);
        waitCycles(3);
        applyStimulus(2'b11, 2'b00);
        waitCycles(10);
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i % 2 == 0) ? 2'b10 : 2'b11, 2'b00);
            waitCycles(2);
        end
        waitCycles(10);
        checkOutput("bounce_level", int'(key_level), 0);

        // Both keys together
        applyStimulus(2'b00, 2'b11);
        waitCycles(30);
        applyStimulus(2'b11, 2'b11);
        waitCycles(20);

        // Key 1 held, key 0 mid-check, then asynchronous reset
        applyStimulus(2'b01, 2'b10);
        waitCycles(20);
        applyStimulus(2'b00, 2'b00);
        waitCycles(2);
        #2;
        reset = 1'b1;
        sb.delete();
        expLevel = '0;
        key_raw  = 2'b11;
        #1;
        checkOutput("async_rst_level", int'(key_level), 0);
        checkOutput("async_rst_press", int'(key_press), 0);
        waitCycles(3);
        reset = 1'b0;
        waitCycles(30);

        checkOutput("sb_leftover", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
